// File: rtl/hazard_sb.sv
// Pipeline hazard unit: forwarding selects, load/branch/scoreboard/divider stalls.
// Optional macro HAZARD_SB_WBFWD_EN releases D in the long-latency writeback cycle.
module hazard_sb #(
   parameter int unsigned AW      = 5,
   parameter int unsigned NREG    = 32,
   parameter int unsigned DIV_LAT = 32,
   parameter int unsigned CW      = 8
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic [AW-1:0]   rsD,
   input  logic [AW-1:0]   rtD,
   input  logic [AW-1:0]   writeregD,
   input  logic            regwriteD,
   input  logic            branchD,
   input  logic            jumprD,
   input  logic [AW-1:0]   rsE,
   input  logic [AW-1:0]   rtE,
   input  logic [AW-1:0]   writeregE,
   input  logic            regwriteE,
   input  logic            memtoregE,
   input  logic            div_startE,
   input  logic [AW-1:0]   writeregM,
   input  logic            regwriteM,
   input  logic            memtoregM,
   input  logic [AW-1:0]   writeregW,
   input  logic            regwriteW,
   input  logic            ll_issue,
   input  logic [AW-1:0]   ll_reg,
   input  logic            ll_done,
   input  logic [AW-1:0]   ll_done_reg,
   output logic            forwardaD,
   output logic            forwardbD,
   output logic [1:0]      forwardaE,
   output logic [1:0]      forwardbE,
   output logic            stallF,
   output logic            stallD,
   output logic            stallE,
   output logic            flushE,
   output logic            div_busy,
   output logic [NREG-1:0] sb_pending
);

   localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_LAT - 2);

   typedef enum logic {S_IDLE, S_BUSY} div_state_t;

   div_state_t       r_state, w_state_nxt;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic [NREG-1:0]  r_pending, w_pending_nxt, w_set, w_clr, w_pend_vis;
   logic             w_lwstall, w_brstall, w_sbstall, w_divstall;
   logic             w_rsD_nz, w_rtD_nz, w_rsE_nz, w_rtE_nz;

   assign w_rsD_nz = (rsD != '0);
   assign w_rtD_nz = (rtD != '0);
   assign w_rsE_nz = (rsE != '0);
   assign w_rtE_nz = (rtE != '0);

   // Forwarding selects: M has priority over W in E.
   always_comb begin
      forwardaD = w_rsD_nz & (rsD == writeregM) & regwriteM;
      forwardbD = w_rtD_nz & (rtD == writeregM) & regwriteM;
      forwardaE = 2'b00;
      forwardbE = 2'b00;
      if (w_rsE_nz & (rsE == writeregM) & regwriteM)      forwardaE = 2'b10;
      else if (w_rsE_nz & (rsE == writeregW) & regwriteW) forwardaE = 2'b01;
      if (w_rtE_nz & (rtE == writeregM) & regwriteM)      forwardbE = 2'b10;
      else if (w_rtE_nz & (rtE == writeregW) & regwriteW) forwardbE = 2'b01;
   end

   // Scoreboard next state: clear completed write, then set new issue (newer wins).
   always_comb begin
      w_set         = ll_issue ? (NREG'(1) << ll_reg)      : '0;
      w_clr         = ll_done  ? (NREG'(1) << ll_done_reg) : '0;
      w_pending_nxt = ((r_pending & ~w_clr) | w_set) & ~NREG'(1);
`ifdef HAZARD_SB_WBFWD_EN
      w_pend_vis    = r_pending & ~w_clr;
`else
      w_pend_vis    = r_pending;
`endif
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_pending <= '0;
      else         r_pending <= w_pending_nxt;
   end

   // Divider occupancy FSM.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (div_startE) begin
               w_state_nxt = S_BUSY;
               w_cnt_nxt   = CNT_LOAD;
            end
         end
         S_BUSY: begin
            if (r_cnt == '0) w_state_nxt = S_IDLE;
            else             w_cnt_nxt   = r_cnt - CW'(1);
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Stall covers the start cycle plus every BUSY cycle, DIV_LAT cycles in total.
   always_comb begin
      div_busy   = (r_state == S_BUSY);
      w_divstall = (div_startE & ~div_busy) | div_busy;
      w_lwstall  = memtoregE & w_rtE_nz & ((rtE == rsD) | (rtE == rtD));
      w_brstall  = (branchD | jumprD) &
                   ((regwriteE & ((w_rsD_nz & (writeregE == rsD)) | (w_rtD_nz & (writeregE == rtD)))) |
                    (memtoregM & ((w_rsD_nz & (writeregM == rsD)) | (w_rtD_nz & (writeregM == rtD)))));
      w_sbstall  = w_pend_vis[rsD] | w_pend_vis[rtD] | (regwriteD & w_pend_vis[writeregD]);
      stallD     = w_lwstall | w_brstall | w_sbstall | w_divstall;
      stallF     = stallD;
      stallE     = w_divstall;
      flushE     = (w_lwstall | w_brstall | w_sbstall) & ~w_divstall;
      sb_pending = r_pending;
   end

endmodule

// File: tb/tb_hazard_sb.sv
// Directed self-checking bench for hazard_sb (default parameters).
module tb_hazard_sb;

   localparam int unsigned AW = 5;
   localparam int unsigned NREG = 32;
`ifdef HAZARD_SB_WBFWD_EN
   localparam logic WBFWD = 1'b1;
`else
   localparam logic WBFWD = 1'b0;
`endif

   logic clk = 1'b0;
   logic resetn;
   logic [AW-1:0] rsD, rtD, writeregD, rsE, rtE, writeregE, writeregM, writeregW, ll_reg, ll_done_reg;
   logic regwriteD, branchD, jumprD, regwriteE, memtoregE, div_startE;
   logic regwriteM, memtoregM, regwriteW, ll_issue, ll_done;
   logic forwardaD, forwardbD, stallF, stallD, stallE, flushE, div_busy;
   logic [1:0] forwardaE, forwardbE;
   logic [NREG-1:0] sb_pending;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   hazard_sb #(.AW(AW), .NREG(NREG), .DIV_LAT(32), .CW(8)) dut (
      .clk(clk), .resetn(resetn),
      .rsD(rsD), .rtD(rtD), .writeregD(writeregD),
      .regwriteD(regwriteD), .branchD(branchD), .jumprD(jumprD),
      .rsE(rsE), .rtE(rtE), .writeregE(writeregE),
      .regwriteE(regwriteE), .memtoregE(memtoregE), .div_startE(div_startE),
      .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
      .writeregW(writeregW), .regwriteW(regwriteW),
      .ll_issue(ll_issue), .ll_reg(ll_reg), .ll_done(ll_done), .ll_done_reg(ll_done_reg),
      .forwardaD(forwardaD), .forwardbD(forwardbD),
      .forwardaE(forwardaE), .forwardbE(forwardbE),
      .stallF(stallF), .stallD(stallD), .stallE(stallE), .flushE(flushE),
      .div_busy(div_busy), .sb_pending(sb_pending)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic clr_in();
      rsD = '0; rtD = '0; writeregD = '0; rsE = '0; rtE = '0; writeregE = '0;
      writeregM = '0; writeregW = '0; ll_reg = '0; ll_done_reg = '0;
      regwriteD = 0; branchD = 0; jumprD = 0; regwriteE = 0; memtoregE = 0; div_startE = 0;
      regwriteM = 0; memtoregM = 0; regwriteW = 0; ll_issue = 0; ll_done = 0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   // Issuing to a register that is still pending is a protocol error.
   always @(posedge clk)
      if (resetn && ll_issue && ll_reg != '0)
         assert (!sb_pending[ll_reg]) else $error("protocol: ll_issue to pending register %0d", ll_reg);

   initial begin
      int nst, nbusy, nflush, ndiff, first, last;
      clr_in();
      resetn = 1'b0;
      #2;
      check("rst_stallD", stallD, 0);
      check("rst_flushE", flushE, 0);
      check("rst_fwdaE", forwardaE, 0);
      check("rst_busy", div_busy, 0);
      check("rst_pend", sb_pending, 0);
      @(negedge clk);
      resetn = 1'b1;

      // Load-use
      cyc(); memtoregE = 1; rtE = 8; rsD = 8; smp();
      check("lu_stallD", stallD, 1);
      check("lu_stallF", stallF, 1);
      check("lu_flushE", flushE, 1);
      check("lu_stallE", stallE, 0);
      cyc(); memtoregE = 0; rsE = 8; writeregW = 8; regwriteW = 1; smp();
      check("lu2_stallD", stallD, 0);
      check("lu2_flushE", flushE, 0);
      check("lu2_fwdaE", forwardaE, 2'b01);

      // Dual match and register 0
      cyc(); clr_in(); rsE = 5; rtE = 6; writeregM = 5; writeregW = 5; regwriteM = 1; regwriteW = 1; rsD = 5; smp();
      check("dual_fwdaE", forwardaE, 2'b10);
      check("dual_fwdbE", forwardbE, 2'b00);
      check("dual_fwdaD", forwardaD, 1);
      check("dual_fwdbD", forwardbD, 0);
      cyc(); rsE = 0; rsD = 0; writeregM = 0; writeregW = 0; smp();
      check("r0_fwdaE", forwardaE, 2'b00);
      check("r0_fwdaD", forwardaD, 0);

      // Branch stalls
      cyc(); clr_in(); branchD = 1; rtD = 7; regwriteE = 1; writeregE = 7; smp();
      check("br_stallD", stallD, 1);
      check("br_flushE", flushE, 1);
      cyc(); rtD = 0; writeregE = 0; smp();
      check("br0_stallD", stallD, 0);
      cyc(); clr_in(); jumprD = 1; rsD = 9; memtoregM = 1; writeregM = 9; smp();
      check("brm_stallD", stallD, 1);

      // Divider: start at rel 0, ignored restart at rel 10
      cyc(); clr_in(); smp();
      nst = 0; nbusy = 0; nflush = 0; ndiff = 0; first = -1; last = -1;
      for (int c = 0; c < 40; c++) begin
         cyc(); div_startE = (c == 0 || c == 10); smp();
         if (stallE) begin nst++; if (first < 0) first = c; last = c; end
         if (div_busy) nbusy++;
         if (flushE) nflush++;
         if (stallD != stallE) ndiff++;
      end
      check("div_stall_cycles", nst, 32);
      check("div_first", first, 0);
      check("div_last", last, 31);
      check("div_busy_cycles", nbusy, 31);
      check("div_flush", nflush, 0);
      check("div_stallD_eq_E", ndiff, 0);

      // Scoreboard
      cyc(); clr_in(); ll_issue = 1; ll_reg = 12; rsD = 12; smp();
      check("sb_pre_stallD", stallD, 0);
      cyc(); ll_issue = 0; smp();
      check("sb_stallD", stallD, 1);
      check("sb_flushE", flushE, 1);
      check("sb_pend", sb_pending, 32'h0000_1000);
      repeat (3) cyc();
      ll_done = 1; ll_done_reg = 12; smp();
      check("sb_done_stallD", stallD, !WBFWD);
      cyc(); ll_done = 0; smp();
      check("sb_after_stallD", stallD, 0);
      check("sb_after_pend", sb_pending, 0);

      // Simultaneous set/clear on reg 3, then WAW
      cyc(); clr_in(); ll_done = 1; ll_done_reg = 3; ll_issue = 1; ll_reg = 3; smp();
      cyc(); clr_in(); regwriteD = 1; writeregD = 3; smp();
      check("simul_pend", sb_pending, 32'h0000_0008);
      check("waw_stallD", stallD, 1);
      check("waw_flushE", flushE, 1);
      cyc(); clr_in(); ll_issue = 1; ll_reg = 0; smp();
      cyc(); ll_issue = 0; smp();
      check("r0_pend", sb_pending, 32'h0000_0008);

      // Asynchronous reset mid-divide with a pending bit
      cyc(); div_startE = 1; smp();
      cyc(); div_startE = 0; smp();
      check("ar_pre_busy", div_busy, 1);
      cyc(); #1; resetn = 1'b0; #1;
      check("ar_busy", div_busy, 0);
      check("ar_pend", sb_pending, 0);
      check("ar_stallE", stallE, 0);
      @(negedge clk);
      resetn = 1'b1;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
